// File: rtl/z_core_control_unit.sv
// Z-Core RV32I multi-cycle control sequencer.
// Steps each instruction through fetch/decode/execute/mem/writeback.
module z_core_control_unit #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [4:0] rd,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_valid,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic [2:0] imm_sel,
  output logic [1:0] alu_mode,
  output logic       retire,
  output logic       halted,
  output logic       illegal_inst,
  output logic       bus_error
);

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OPIMM  = 7'h13;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_wait_cnt;
  logic        r_illegal;
  logic        r_bus_err;
  logic        w_set_ill;
  logic        w_set_bus;
  logic        w_to_hit;
  logic        w_rd_nz;

  logic w_lui, w_auipc, w_jal, w_jalr, w_branch;
  logic w_load, w_store, w_opimm, w_opr, w_fence, w_system;
  logic w_legal;

  // ALU/immediate selects implied by the opcode
  logic       w_a_sel;
  logic       w_b_sel;
  logic [2:0] w_imm_sel;
  logic [1:0] w_mode;

  // funct3 is consumed by the ALU itself, not by sequencing
  logic w_unused_funct3;
  assign w_unused_funct3 = ^funct3;

  assign w_lui    = (op == OP_LUI);
  assign w_auipc  = (op == OP_AUIPC);
  assign w_jal    = (op == OP_JAL);
  assign w_jalr   = (op == OP_JALR);
  assign w_branch = (op == OP_BRANCH);
  assign w_load   = (op == OP_LOAD);
  assign w_store  = (op == OP_STORE);
  assign w_opimm  = (op == OP_OPIMM);
  assign w_opr    = (op == OP_OP);
  assign w_fence  = (op == OP_FENCE);
  assign w_system = (op == OP_SYSTEM);

  assign w_legal = w_lui | w_auipc | w_jal | w_jalr
                 | w_branch | w_load | w_store
                 | w_opimm | w_opr | w_fence | w_system;

  assign w_rd_nz = (rd != 5'd0);

  // Wait counter has reached the limit on this waiting cycle
  assign w_to_hit = (TIMEOUT_CYCLES != 0) &&
    ((32'(r_wait_cnt) + 32'd1) >= 32'(TIMEOUT_CYCLES));

  // Datapath selects per opcode class
  always_comb begin
    w_a_sel   = 1'b0;
    w_b_sel   = 1'b0;
    w_imm_sel = 3'd0;
    w_mode    = 2'd0;
    unique case (1'b1)
      w_opr: begin
        w_mode = 2'd1;
      end
      w_opimm: begin
        w_b_sel = 1'b1;
        w_mode  = 2'd1;
      end
      w_lui: begin
        w_b_sel   = 1'b1;
        w_imm_sel = 3'd3;
        w_mode    = 2'd2;
      end
      w_auipc: begin
        w_a_sel   = 1'b1;
        w_b_sel   = 1'b1;
        w_imm_sel = 3'd3;
      end
      w_load: begin
        w_b_sel = 1'b1;
      end
      w_store: begin
        w_b_sel   = 1'b1;
        w_imm_sel = 3'd1;
      end
      w_branch: begin
        w_imm_sel = 3'd2;
        w_mode    = 2'd1;
      end
      w_jal: begin
        w_imm_sel = 3'd4;
      end
      w_jalr: begin
        w_b_sel = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state and control outputs
  always_comb begin
    w_next       = r_state;
    w_set_ill    = 1'b0;
    w_set_bus    = 1'b0;
    mem_valid    = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    imm_sel      = 3'd0;
    alu_mode     = 2'd0;
    retire       = 1'b0;
    unique case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        mem_valid = 1'b1;
        if (mem_ready) begin
          ir_we  = 1'b1;
          w_next = S_DECODE;
        end else if (w_to_hit) begin
          w_set_bus = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_DECODE: begin
        if (!w_legal) begin
          w_set_ill = 1'b1;
          w_next    = S_HALT;
        end else if (w_system) begin
          retire = 1'b1;
          w_next = S_HALT;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_a_sel = w_a_sel;
        alu_b_sel = w_b_sel;
        imm_sel   = w_imm_sel;
        alu_mode  = w_mode;
        unique case (1'b1)
          w_branch: begin
            pc_we  = 1'b1;
            pc_sel = branch_taken ? 2'd1 : 2'd0;
            retire = 1'b1;
            w_next = S_FETCH;
          end
          w_jal: begin
            pc_we  = 1'b1;
            pc_sel = 2'd1;
            wb_sel = 2'd2;
            rf_we  = w_rd_nz;
            retire = 1'b1;
            w_next = S_FETCH;
          end
          w_jalr: begin
            pc_we  = 1'b1;
            pc_sel = 2'd2;
            wb_sel = 2'd2;
            rf_we  = w_rd_nz;
            retire = 1'b1;
            w_next = S_FETCH;
          end
          w_fence: begin
            pc_we  = 1'b1;
            retire = 1'b1;
            w_next = S_FETCH;
          end
          (w_load | w_store): w_next = S_MEM;
          default: w_next = S_WB;
        endcase
      end
      S_MEM: begin
        alu_a_sel    = w_a_sel;
        alu_b_sel    = w_b_sel;
        imm_sel      = w_imm_sel;
        alu_mode     = w_mode;
        mem_valid    = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = w_store;
        if (mem_ready) begin
          if (w_store) begin
            pc_we  = 1'b1;
            retire = 1'b1;
            w_next = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (w_to_hit) begin
          w_set_bus = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_WB: begin
        alu_a_sel = w_a_sel;
        alu_b_sel = w_b_sel;
        imm_sel   = w_imm_sel;
        alu_mode  = w_mode;
        rf_we     = w_rd_nz;
        wb_sel    = w_load ? 2'd1 : 2'd0;
        pc_we     = 1'b1;
        retire    = 1'b1;
        w_next    = S_FETCH;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  assign halted       = (r_state == S_HALT);
  assign illegal_inst = r_illegal;
  assign bus_error    = r_bus_err;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Memory wait counter: cleared on entering a request state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wait_cnt <= 16'd0;
    end else if ((w_next != r_state) &&
                 ((w_next == S_FETCH) || (w_next == S_MEM))) begin
      r_wait_cnt <= 16'd0;
    end else if (mem_valid && !mem_ready &&
                 (r_wait_cnt != 16'hFFFF)) begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end

  // Sticky halt causes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_set_ill) r_illegal <= 1'b1;
      if (w_set_bus) r_bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_z_core_control_unit.sv
// Bench for z_core_control_unit: instruction table plus
// hand-written halt, timeout and reset sequences.
module tb_z_core_control_unit;

  logic       clk = 1'b0;
  logic       rstn;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic       branch_taken;
  logic       mem_ready;

  logic       mem_valid, mem_we, mem_addr_sel, ir_we, pc_we;
  logic [1:0] pc_sel, wb_sel, alu_mode;
  logic       rf_we, alu_a_sel, alu_b_sel;
  logic [2:0] imm_sel;
  logic       retire, halted, illegal_inst, bus_error;

  logic       t_mem_valid, t_mem_we, t_mem_addr_sel, t_ir_we;
  logic       t_pc_we;
  logic [1:0] t_pc_sel, t_wb_sel, t_alu_mode;
  logic       t_rf_we, t_alu_a_sel, t_alu_b_sel;
  logic [2:0] t_imm_sel;
  logic       t_retire, t_halted, t_illegal_inst, t_bus_error;

  logic [20:0] d_vec, t_vec;

  assign d_vec = {mem_valid, mem_we, mem_addr_sel, ir_we,
                  pc_we, pc_sel, rf_we, wb_sel, alu_a_sel,
                  alu_b_sel, imm_sel, alu_mode, retire,
                  halted, illegal_inst, bus_error};
  assign t_vec = {t_mem_valid, t_mem_we, t_mem_addr_sel,
                  t_ir_we, t_pc_we, t_pc_sel, t_rf_we,
                  t_wb_sel, t_alu_a_sel, t_alu_b_sel,
                  t_imm_sel, t_alu_mode, t_retire, t_halted,
                  t_illegal_inst, t_bus_error};

  always #5 clk = ~clk;

  z_core_control_unit u_dut (
    .clk(clk), .rstn(rstn), .op(op), .funct3(funct3),
    .rd(rd), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_valid(mem_valid),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .rf_we(rf_we), .wb_sel(wb_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .imm_sel(imm_sel),
    .alu_mode(alu_mode), .retire(retire), .halted(halted),
    .illegal_inst(illegal_inst), .bus_error(bus_error)
  );

  z_core_control_unit #(.TIMEOUT_CYCLES(8)) u_dut_to (
    .clk(clk), .rstn(rstn), .op(op), .funct3(funct3),
    .rd(rd), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_valid(t_mem_valid),
    .mem_we(t_mem_we), .mem_addr_sel(t_mem_addr_sel),
    .ir_we(t_ir_we), .pc_we(t_pc_we), .pc_sel(t_pc_sel),
    .rf_we(t_rf_we), .wb_sel(t_wb_sel),
    .alu_a_sel(t_alu_a_sel), .alu_b_sel(t_alu_b_sel),
    .imm_sel(t_imm_sel), .alu_mode(t_alu_mode),
    .retire(t_retire), .halted(t_halted),
    .illegal_inst(t_illegal_inst), .bus_error(t_bus_error)
  );

  typedef struct {
    logic [6:0] op;
    logic [4:0] rd;
    logic       br;
    int         fw;
    int         mw;
    int         cyc;
    logic       rf;
    logic [1:0] wb;
    logic [1:0] pcs;
    logic       a;
    logic       b;
    logic [2:0] imm;
    logic [1:0] mode;
    logic       mwe;
    logic [4:0] msk;  // {mode, wb, a, b, imm} checked
  } vec_t;

  vec_t tbl[16];
  vec_t sb[$];
  vec_t v_addi;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one instruction from FETCH entry up to its retire
  task automatic run_instr(input vec_t v, input int idx);
    int   cyc;
    int   phase;
    int   wcnt;
    int   need;
    bit   done;
    vec_t e;
    sb.push_back(v);
    op = v.op;
    rd = v.rd;
    branch_taken = v.br;
    cyc = 0; phase = 0; wcnt = 0; done = 0;
    while (!done && cyc < 40) begin
      cyc++;
      mem_ready = 1'b0;
      #1;
      if (mem_valid) begin
        need = (phase != 0) ? v.mw : v.fw;
        chk($sformatf("v%0d addr_sel", idx),
            32'(mem_addr_sel), phase);
        chk($sformatf("v%0d mem_we", idx), 32'(mem_we),
            (phase != 0) ? 32'(v.mwe) : 0);
        if (wcnt >= need) mem_ready = 1'b1;
        else wcnt++;
      end
      #1;
      if (mem_valid && mem_ready && phase == 0)
        chk($sformatf("v%0d ir_we", idx), 32'(ir_we), 1);
      if (retire) begin
        done = 1;
        e = sb.pop_front();
        chk($sformatf("v%0d cycles", idx), cyc, e.cyc);
        chk($sformatf("v%0d pc_we", idx), 32'(pc_we), 1);
        chk($sformatf("v%0d pc_sel", idx),
            32'(pc_sel), 32'(e.pcs));
        chk($sformatf("v%0d rf_we", idx),
            32'(rf_we), 32'(e.rf));
        if (e.msk[4]) chk($sformatf("v%0d alu_mode", idx),
                          32'(alu_mode), 32'(e.mode));
        if (e.msk[3]) chk($sformatf("v%0d wb_sel", idx),
                          32'(wb_sel), 32'(e.wb));
        if (e.msk[2]) chk($sformatf("v%0d alu_a", idx),
                          32'(alu_a_sel), 32'(e.a));
        if (e.msk[1]) chk($sformatf("v%0d alu_b", idx),
                          32'(alu_b_sel), 32'(e.b));
        if (e.msk[0]) chk($sformatf("v%0d imm_sel", idx),
                          32'(imm_sel), 32'(e.imm));
      end
      if (mem_valid && mem_ready) begin
        phase = 1;
        wcnt  = 0;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL v%0d retire: no retire within 40 cycles", idx);
      void'(sb.pop_front());
    end
  endtask

  // Reset pulse; returns #1 after the edge that enters FETCH
  task automatic do_reset();
    rstn = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    // op, rd, br, fw, mw, cyc, rf, wb, pcs, a, b, imm, mode, mwe, msk
    tbl[0]  = '{7'h13, 5'd5, 0, 0, 0, 4, 1, 0, 0, 0, 1, 0, 1, 0, 5'b11011};
    tbl[1]  = '{7'h13, 5'd0, 0, 0, 0, 4, 0, 0, 0, 0, 1, 0, 1, 0, 5'b11011};
    tbl[2]  = '{7'h33, 5'd3, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1, 0, 5'b11010};
    tbl[3]  = '{7'h37, 5'd1, 0, 0, 0, 4, 1, 0, 0, 0, 1, 3, 2, 0, 5'b11011};
    tbl[4]  = '{7'h17, 5'd2, 0, 0, 0, 4, 1, 0, 0, 1, 1, 3, 0, 0, 5'b11111};
    tbl[5]  = '{7'h03, 5'd7, 0, 0, 0, 5, 1, 1, 0, 0, 1, 0, 0, 0, 5'b11011};
    tbl[6]  = '{7'h03, 5'd7, 0, 2, 2, 9, 1, 1, 0, 0, 1, 0, 0, 0, 5'b11011};
    tbl[7]  = '{7'h23, 5'd9, 0, 0, 0, 4, 0, 0, 0, 0, 1, 1, 0, 1, 5'b10011};
    tbl[8]  = '{7'h23, 5'd3, 0, 1, 3, 8, 0, 0, 0, 0, 1, 1, 0, 1, 5'b10011};
    tbl[9]  = '{7'h63, 5'd6, 1, 0, 0, 3, 0, 0, 1, 0, 0, 2, 1, 0, 5'b10001};
    tbl[10] = '{7'h63, 5'd6, 0, 0, 0, 3, 0, 0, 0, 0, 0, 2, 1, 0, 5'b10001};
    tbl[11] = '{7'h6F, 5'd1, 0, 0, 0, 3, 1, 2, 1, 0, 0, 4, 0, 0, 5'b01001};
    tbl[12] = '{7'h6F, 5'd0, 0, 0, 0, 3, 0, 2, 1, 0, 0, 4, 0, 0, 5'b01001};
    tbl[13] = '{7'h67, 5'd5, 0, 0, 0, 3, 1, 2, 2, 0, 1, 0, 0, 0, 5'b11011};
    tbl[14] = '{7'h0F, 5'd0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000};
    tbl[15] = '{7'h13, 5'd1, 0, 3, 0, 7, 1, 0, 0, 0, 1, 0, 1, 0, 5'b11011};
    v_addi  = tbl[0];

    rstn = 1'b0;
    op = 7'h13;
    funct3 = 3'd0;
    rd = 5'd0;
    branch_taken = 1'b0;
    mem_ready = 1'b0;

    // Reset and first IDLE cycle
    repeat (3) @(posedge clk);
    #1 chk("reset outputs", 32'(d_vec), 0);
    rstn = 1'b1;
    #1 chk("idle outputs", 32'(d_vec), 0);
    @(posedge clk);
    #1 chk("first fetch valid", 32'(mem_valid), 1);

    for (int i = 0; i < 16; i++) run_instr(tbl[i], i);

    // Illegal opcode halts without retiring
    op = 7'h7F;
    rd = 5'd0;
    mem_ready = 1'b1;
    #1;
    @(posedge clk);
    #1 mem_ready = 1'b0;
    chk("illegal decode retire", 32'(retire), 0);
    @(posedge clk);
    #1 chk("illegal halt vec", 32'(d_vec), 32'h6);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      mem_ready = k[0];
      @(posedge clk);
      #1;
      if (d_vec !== 21'h6) bad++;
    end
    chk("illegal halt hold bad cycles", bad, 0);

    // ECALL retires on entry to HALT
    do_reset();
    chk("post-reset flags", 32'({illegal_inst, halted}), 0);
    op = 7'h73;
    mem_ready = 1'b1;
    #1;
    @(posedge clk);
    #1 mem_ready = 1'b0;
    chk("ecall retire", 32'(retire), 1);
    @(posedge clk);
    #1 chk("ecall halt vec", 32'(d_vec), 32'h4);

    // Fetch timeout with TIMEOUT_CYCLES=8
    do_reset();
    op = 7'h13;
    repeat (7) @(posedge clk);
    #1;
    chk("timeout 7 waits bus_error", 32'(t_bus_error), 0);
    chk("timeout 7 waits valid", 32'(t_mem_valid), 1);
    @(posedge clk);
    #1 chk("timeout 8 waits vec", 32'(t_vec), 32'h5);
    repeat (20) @(posedge clk);
    #1;
    chk("no-timeout valid", 32'(mem_valid), 1);
    chk("no-timeout bus_error", 32'(bus_error), 0);

    // Reset asserted while a load is waiting in MEM
    do_reset();
    op = 7'h03;
    rd = 5'd4;
    mem_ready = 1'b1;
    #1;
    @(posedge clk);
    #1 mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mem wait valid", 32'(mem_valid), 1);
    chk("mem wait addr_sel", 32'(mem_addr_sel), 1);
    @(posedge clk);
    #1 rstn = 1'b0;
    #1 chk("mid-mem reset vec", 32'(d_vec), 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("refetch valid", 32'(mem_valid), 1);
    chk("refetch addr_sel", 32'(mem_addr_sel), 0);
    run_instr(v_addi, 99);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/z_core_control_unit.md
# z_core_control_unit

Multi-cycle control sequencer for the Z-Core RV32I datapath. It consumes the decoded fields (opcode, funct3, rd) and the branch comparator result. It walks each instruction through fetch, decode, execute, memory and writeback, generating every enable and mux select for the PC, instruction register, register file, ALU and the shared instruction/data memory port. It sits beside the instruction decoder, and it is the only block that drives the memory handshake.

## Interface
- `TIMEOUT_CYCLES`, default 0: maximum wait cycles on a memory request before a bus error is raised. 0 disables the timeout.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `op`  in  7  decoded opcode.
- `funct3`  in  3  decoded funct3.
- `rd`  in  5  decoded destination register.
- `branch_taken`  in  1  comparator result for the current B-type instruction.
- `mem_ready`  in  1  memory accepts or returns the current request.
- `mem_valid`  out  1  memory request active.
- `mem_we`  out  1  request is a store.
- `mem_addr_sel`  out  1  0 = PC, 1 = ALU result.
- `ir_we`  out  1  load instruction register.
- `pc_we`  out  1  update PC.
- `pc_sel`  out  2  0 = PC+4, 1 = PC+imm, 2 = ALU result & ~1.
- `rf_we`  out  1  register-file write.
- `wb_sel`  out  2  0 = ALU, 1 = memory data, 2 = PC+4.
- `alu_a_sel`  out  1  0 = rs1, 1 = PC.
- `alu_b_sel`  out  1  0 = rs2, 1 = immediate.
- `imm_sel`  out  3  0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- `alu_mode`  out  2  0 = forced ADD, 1 = funct-driven, 2 = pass-B (LUI).
- `retire`  out  1  one-cycle pulse per completed instruction.
- `halted`  out  1  sticky; core stopped.
- `illegal_inst`  out  1  sticky cause: unknown opcode.
- `bus_error`  out  1  sticky cause: memory timeout.

## Operation
- **States:** IDLE, FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- **Outputs:** all are combinational from the state and the current `op`/`rd`. In IDLE and HALT every enable and `mem_valid` is 0.
- **IDLE:** the reset state. It moves to FETCH unconditionally on the first clock edge after `rstn` is released.
- **FETCH:**
  - Drives `mem_valid=1`, `mem_addr_sel=0`, `mem_we=0`.
  - On `mem_valid && mem_ready`: `ir_we=1` in that cycle, then go to DECODE.
- **DECODE:** register-file read cycle with no enables asserted.
  - Legal opcodes: 0x37, 0x17, 0x6F, 0x67, 0x63, 0x03, 0x23, 0x13, 0x33, 0x0F, 0x73. Any other opcode goes to HALT with `illegal_inst=1`.
  - 0x73 (ECALL/EBREAK) goes to HALT with `retire` pulsed and no cause flag set.
- **EXECUTE, by opcode:**
  - OP (0x33): `alu_b_sel=0`, `alu_mode=1`; go to WB.
  - OP-IMM (0x13): `alu_b_sel=1`, `imm_sel=I`, `alu_mode=1`; go to WB.
  - LUI: `imm_sel=U`, `alu_b_sel=1`, `alu_mode=2`; go to WB.
  - AUIPC: `alu_a_sel=1`, `alu_b_sel=1`, `imm_sel=U`, `alu_mode=0`; go to WB.
  - LOAD: I-immediate, `alu_mode=0`; go to MEM.
  - STORE: S-immediate, `alu_mode=0`; go to MEM.
  - BRANCH:
    - `imm_sel=B`, `alu_mode=1`, `pc_we=1`.
    - `pc_sel = branch_taken ? 1 : 0`.
    - `retire=1`; go to FETCH.
  - JAL: `imm_sel=J`, `pc_sel=1`, `pc_we=1`, `wb_sel=2`, `rf_we=(rd!=0)`, `retire=1`; go to FETCH.
  - JALR: `imm_sel=I`, `alu_b_sel=1`, `alu_mode=0`, `pc_sel=2`, `pc_we=1`, `wb_sel=2`, `rf_we=(rd!=0)`, `retire=1`; go to FETCH.
  - FENCE: treated as a NOP. `pc_we=1`, `pc_sel=0`, `retire=1`; go to FETCH.
- **MEM:**
  - Drives `mem_valid=1`, `mem_addr_sel=1`, `mem_we=(op==STORE)`, and holds the ALU selects from EXECUTE.
  - On handshake, a load goes to WB.
  - On handshake, a store asserts `pc_we=1`, `pc_sel=0`, `retire=1` and goes to FETCH.
- **WB:**
  - `rf_we=(rd!=0)`.
  - `wb_sel` = 1 for LOAD, 0 otherwise. The ALU selects are held from EXECUTE.
  - `pc_we=1`, `pc_sel=0`, `retire=1`; go to FETCH.
- **Timeout:**
  - A 16-bit wait counter clears on entry to FETCH or MEM and increments each cycle that `mem_valid && !mem_ready`.
  - If `TIMEOUT_CYCLES != 0` and the count reaches `TIMEOUT_CYCLES`, go to HALT with `bus_error=1`.
  - The counter saturates and does not wrap.
- **HALT:**
  - `halted=1`. Only `rstn` exits this state.
  - Cause flags are set on entry and cleared only by reset.

## Timing
- **Reset:** asserting `rstn` forces IDLE immediately and asynchronously, mid-instruction or mid-request. All outputs are 0, and the counter and flags clear. No pending memory request survives reset.
- **Handshake:**
  - While `mem_valid=1` and `mem_ready=0`, `mem_we`, `mem_addr_sel` and the ALU selects must stay stable.
  - `mem_ready` may rise in the same cycle as `mem_valid` (zero-wait). The transfer occurs on the clock edge where both are high.
  - `mem_ready` is ignored when `mem_valid=0`.
- **Cycle counts with zero-wait memory, FETCH through last state:**
  - ALU/LUI/AUIPC: 4.
  - Load: 5.
  - Store: 4.
  - Branch/JAL/JALR/FENCE: 3.
  - Each memory wait cycle adds 1.
- **Pulses:** `retire` is exactly one cycle, asserted in the cycle whose clock edge commits PC. The exception is ECALL/EBREAK, where `retire` pulses on the transition into HALT.

## Test plan
- **Reset:** hold `rstn=0` for 3 cycles, then release → all outputs 0 through the first post-reset cycle (IDLE), `mem_valid=1` on the next cycle.
- **ALU op with `rd`=0:** ADDI (op 0x13) with `rd`=5 and zero-wait memory → `retire` pulses 4 cycles after FETCH entry, with `rf_we=1`, `wb_sel=0`, `alu_b_sel=1`, `imm_sel=0` in WB. The same instruction with `rd=0` → `rf_we` stays 0.
- **Load with wait states:** LW (0x03) with `mem_ready` low for 2 cycles in each of FETCH and MEM → total 9 cycles. `mem_we=0` and `mem_addr_sel` held stable while waiting. `wb_sel=1`, `rf_we=1` in WB.
- **Branch taken vs. not taken:** BEQ with `branch_taken=1` → `pc_sel=1`, `pc_we=1` in EXECUTE. With `branch_taken=0` → `pc_sel=0`. Both take 3 cycles.
- **Halt paths:**
  - Opcode 0x7F → HALT with `illegal_inst=1`, `halted=1` and no `retire`. It stays halted for 50 cycles.
  - ECALL → HALT with `retire` pulsed and `illegal_inst=0`.
- **Timeout and mid-request reset:**
  - `TIMEOUT_CYCLES=8` with `mem_ready` held low in FETCH → `bus_error=1` after 8 wait cycles.
  - Separately, assert `rstn` low mid-MEM → `mem_valid` drops immediately, and a normal fetch follows after release.
